// File: rtl/mac_mul_pkg.sv
// Shared definitions for the pipelined cross-multiply stage: mode encodings,
// lane counts per mode and the mode -> active-lane-count decode.
package mac_mul_pkg;

    typedef enum logic [1:0] {
        MAC_SINGLE = 2'b00,
        MAC_DUAL   = 2'b01,
        MAC_QUAD   = 2'b10
    } mac_mode_e;

    localparam int unsigned MAC_LANES_SINGLE = 1;
    localparam int unsigned MAC_LANES_DUAL   = 2;
    localparam int unsigned MAC_LANES_QUAD   = 4;

    // Active lane count for a mode; 0 flags an unsupported encoding.
    function automatic int unsigned lane_count(input logic [1:0] mode);
        case (mode)
            MAC_SINGLE: lane_count = MAC_LANES_SINGLE;
            MAC_DUAL:   lane_count = MAC_LANES_DUAL;
            MAC_QUAD:   lane_count = MAC_LANES_QUAD;
            default:    lane_count = 0;
        endcase
    endfunction

endpackage

// File: rtl/mac_mul_if.sv
// Operand/result handshake bundle of mac_mul_pipe.
// MAC_MUL_SIGNED_EN adds the in_signed beat qualifier.
interface mac_mul_if #(
    parameter int unsigned CONF_WIDTH = 3,
    parameter int unsigned W          = 8,
    parameter int unsigned LANES      = 4,
    parameter int unsigned INT_WIDTH  = (LANES + 1) * W
);
    logic                  in_valid;
    logic                  in_ready;
    logic [LANES*W-1:0]    A;
    logic [W-1:0]          B;
    logic [CONF_WIDTH-1:0] cfg;
`ifdef MAC_MUL_SIGNED_EN
    logic                  in_signed;
`endif
    logic                  out_valid;
    logic                  out_ready;
    logic [INT_WIDTH-1:0]  C;
    logic [CONF_WIDTH-1:0] out_cfg;
    logic                  cfg_err;

`ifdef MAC_MUL_SIGNED_EN
    modport master (output in_valid, A, B, cfg, in_signed, out_ready,
                    input  in_ready, out_valid, C, out_cfg, cfg_err);
    modport slave  (input  in_valid, A, B, cfg, in_signed, out_ready,
                    output in_ready, out_valid, C, out_cfg, cfg_err);
`else
    modport master (output in_valid, A, B, cfg, out_ready,
                    input  in_ready, out_valid, C, out_cfg, cfg_err);
    modport slave  (input  in_valid, A, B, cfg, out_ready,
                    output in_ready, out_valid, C, out_cfg, cfg_err);
`endif
endinterface

// File: rtl/mac_mul_pipe_lane_mul.sv
// One lane multiplier: (W+1)x(W+1) signed. The extension bit of each operand
// is zero for unsigned and the sign bit for signed, so both paths share it.
module mac_lane_mul #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0]          a,
    input  logic                  a_ext,
    input  logic [W-1:0]          b,
    input  logic                  b_ext,
    output logic signed [2*W+1:0] p
);
    logic signed [W:0] a_s;
    logic signed [W:0] b_s;

    // Extended-operand signed product
    always_comb begin
        a_s = {a_ext, a};
        b_s = {b_ext, b};
        p   = a_s * b_s;
    end
endmodule

// File: rtl/mac_mul_pipe.sv
// mac_mul_pipe: two-stage valid/ready cross-multiply between operand fetch
// and the MAC accumulator. Stage 1 holds per-lane products, lane mask and
// cfg; stage 2 holds the masked shift-add, out_cfg and cfg_err.
// Optional feature macro: MAC_MUL_SIGNED_EN (adds in_signed on the bus).
module mac_mul_pipe
    import mac_mul_pkg::*;
#(
    parameter int unsigned MAC_CONF_WIDTH = 3,
    parameter int unsigned MAC_MIN_WIDTH  = 8,
    parameter int unsigned MAC_LANES      = 4,
    parameter int unsigned MAC_MULT_WIDTH = 2 * MAC_MIN_WIDTH,
    parameter int unsigned MAC_INT_WIDTH  = (MAC_LANES + 1) * MAC_MIN_WIDTH
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     en,
    mac_mul_if.slave bus
);
    localparam int unsigned W  = MAC_MIN_WIDTH;
    localparam int unsigned PW = MAC_MULT_WIDTH + 2;

    logic                     sgn;
    int unsigned              n_act;
    logic                     legal;
    logic                     b_ext;
    logic [W-1:0]             lane_a [MAC_LANES];
    logic [MAC_LANES-1:0]     a_ext;
    logic [MAC_LANES-1:0]     in_mask;
    logic signed [PW-1:0]     prod [MAC_LANES];

    logic                     s1_adv, s2_adv;
    logic                     s1_valid_q, s1_valid_d;
    logic signed [PW-1:0]     s1_prod_q [MAC_LANES];
    logic signed [PW-1:0]     s1_prod_d [MAC_LANES];
    logic [MAC_LANES-1:0]     s1_mask_q, s1_mask_d;
    logic [MAC_CONF_WIDTH-1:0] s1_cfg_q, s1_cfg_d;

    logic [MAC_INT_WIDTH-1:0] sum;
    logic                     s2_valid_q, s2_valid_d;
    logic [MAC_INT_WIDTH-1:0] c_q, c_d;
    logic [MAC_CONF_WIDTH-1:0] out_cfg_q, out_cfg_d;
    logic                     cfg_err_q, cfg_err_d;

`ifdef MAC_MUL_SIGNED_EN
    assign sgn = bus.in_signed;
`else
    assign sgn = 1'b0;
`endif

    // Lane split, active mask and per-lane extension bits; only the top
    // active lane of A is sign-extended in signed mode
    always_comb begin
        n_act = lane_count(bus.cfg[1:0]);
        legal = (n_act != 0) && (n_act <= MAC_LANES);
        b_ext = sgn & bus.B[W-1];
        for (int unsigned i = 0; i < MAC_LANES; i++) begin
            lane_a[i]  = bus.A[i*W +: W];
            in_mask[i] = legal && (i < n_act);
            a_ext[i]   = sgn && legal && (i + 1 == n_act) && bus.A[i*W + W - 1];
        end
    end

    for (genvar g = 0; g < MAC_LANES; g++) begin : g_lane
        mac_lane_mul #(.W(W)) u_lane (
            .a     (lane_a[g]),
            .a_ext (a_ext[g]),
            .b     (bus.B),
            .b_ext (b_ext),
            .p     (prod[g])
        );
    end

    // Advance conditions, backward from the output
    always_comb begin
        s2_adv = !s2_valid_q || bus.out_ready;
        s1_adv = !s1_valid_q || s2_adv;
    end

    // Stage 1 next state: capture a beat whenever the stage advances
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_prod_d  = s1_prod_q;
        s1_mask_d  = s1_mask_q;
        s1_cfg_d   = s1_cfg_q;
        if (en && s1_adv) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_prod_d = prod;
                s1_mask_d = in_mask;
                s1_cfg_d  = bus.cfg;
            end
        end
    end

    // Stage 2 next state: masked shift-add; an empty mask marks an illegal cfg
    always_comb begin
        s2_valid_d = s2_valid_q;
        c_d        = c_q;
        out_cfg_d  = out_cfg_q;
        cfg_err_d  = cfg_err_q;
        sum        = '0;
        for (int unsigned i = 0; i < MAC_LANES; i++) begin
            if (s1_mask_q[i])
                sum = sum + (MAC_INT_WIDTH'(s1_prod_q[i]) << (i * W));
        end
        if (en && s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                c_d       = sum;
                out_cfg_d = s1_cfg_q;
                cfg_err_d = (s1_mask_q == '0);
            end
        end
    end

    // Pipeline registers; reset discards any in-flight beats
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_prod_q  <= '{default: '0};
            s1_mask_q  <= '0;
            s1_cfg_q   <= '0;
            s2_valid_q <= 1'b0;
            c_q        <= '0;
            out_cfg_q  <= '0;
            cfg_err_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_prod_q  <= s1_prod_d;
            s1_mask_q  <= s1_mask_d;
            s1_cfg_q   <= s1_cfg_d;
            s2_valid_q <= s2_valid_d;
            c_q        <= c_d;
            out_cfg_q  <= out_cfg_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    assign bus.in_ready  = en && s1_adv;
    assign bus.out_valid = s2_valid_q;
    assign bus.C         = c_q;
    assign bus.out_cfg   = out_cfg_q;
    assign bus.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_mac_mul_pipe.sv
// Self-checking bench for mac_mul_pipe (W=8, 4 lanes): directed cases plus
// randomized traffic against a queue-based arithmetic model.
// Define MAC_MUL_SIGNED_EN to also exercise the signed mode.
module tb_mac_mul_pipe;
    import mac_mul_pkg::*;

    typedef struct {
        logic [39:0] c;
        logic [2:0]  cfg;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic en;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];

    logic        prev_hold = 1'b0;
    logic [39:0] prev_c;
    logic [2:0]  prev_cfg;
    logic        prev_err;

    always #5 clk = ~clk;

    mac_mul_if #(.CONF_WIDTH(3), .W(8), .LANES(4), .INT_WIDTH(40)) bus ();

    mac_mul_pipe #(
        .MAC_CONF_WIDTH (3),
        .MAC_MIN_WIDTH  (8),
        .MAC_LANES      (4),
        .MAC_MULT_WIDTH (16),
        .MAC_INT_WIDTH  (40)
    ) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Arithmetic reference: value of the active-lane concatenation times B
    function automatic exp_t model(input logic [31:0] a, input logic [7:0] b,
                                   input logic [2:0] cfg, input logic sgn);
        exp_t   e;
        int     n;
        longint av, bv, p;
        if (cfg[1:0] == MAC_SINGLE)     n = 1;
        else if (cfg[1:0] == MAC_DUAL)  n = 2;
        else if (cfg[1:0] == MAC_QUAD)  n = 4;
        else                            n = 0;
        e.cfg = cfg;
        if (n == 0 || n > 4) begin
            e.c   = '0;
            e.err = 1'b1;
            return e;
        end
        av = longint'(a) & ((64'sd1 <<< (n * 8)) - 1);
        bv = longint'(b);
        if (sgn && a[n*8-1]) av = av - (64'sd1 <<< (n * 8));
        if (sgn && b[7])     bv = bv - 256;
        p     = av * bv;
        e.c   = p[39:0];
        e.err = 1'b0;
        return e;
    endfunction

    // Scoreboard: pushes accepted beats, pops and checks completed results,
    // and checks hold during stalls and in_ready against occupancy
    always @(negedge clk) begin
        logic fire_out;
        logic s_in;
        exp_t e;
        if (!rst) begin
            chk("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
            exp_q.delete();
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", {63'd0, bus.out_valid}, 64'd1);
                chk("hold_c",     {24'd0, bus.C},         {24'd0, prev_c});
                chk("hold_cfg",   {61'd0, bus.out_cfg},   {61'd0, prev_cfg});
                chk("hold_err",   {63'd0, bus.cfg_err},   {63'd0, prev_err});
            end
            chk("in_ready", {63'd0, bus.in_ready},
                {63'd0, en && (exp_q.size() < 2 || bus.out_ready)});
            fire_out = bus.out_valid && bus.out_ready && en;
            if (fire_out) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", {63'd0, bus.out_valid}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("result_c",   {24'd0, bus.C},       {24'd0, e.c});
                    chk("result_cfg", {61'd0, bus.out_cfg}, {61'd0, e.cfg});
                    chk("result_err", {63'd0, bus.cfg_err}, {63'd0, e.err});
                end
            end
            prev_hold = bus.out_valid && !fire_out;
            prev_c    = bus.C;
            prev_cfg  = bus.out_cfg;
            prev_err  = bus.cfg_err;
            if (bus.in_valid && bus.in_ready) begin
`ifdef MAC_MUL_SIGNED_EN
                s_in = bus.in_signed;
`else
                s_in = 1'b0;
`endif
                exp_q.push_back(model(bus.A, bus.B, bus.cfg, s_in));
            end
        end
    end

    // Present a beat and hold it until accepted; called and returns at posedge+2
    task automatic send(input logic [31:0] a, input logic [7:0] b,
                        input logic [2:0] c, input logic s);
        logic done = 1'b0;
        bus.A = a;
        bus.B = b;
        bus.cfg = c;
`ifdef MAC_MUL_SIGNED_EN
        bus.in_signed = s;
`endif
        bus.in_valid = 1'b1;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            done = bus.in_ready;
            @(posedge clk);
            #2;
        end
        bus.in_valid = 1'b0;
        chk("send_accepted", {63'd0, done}, 64'd1);
    endtask

    task automatic wait_drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        chk("drain_left", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #2;
    endtask

    initial begin
        exp_t m;
        rst = 1'b0;
        en = 1'b1;
        bus.in_valid = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.cfg = '0;
        bus.out_ready = 1'b1;
`ifdef MAC_MUL_SIGNED_EN
        bus.in_signed = 1'b0;
`endif
        // Model pinned to hand-computed values
        m = model(32'hAAAA1234, 8'h56, {1'b0, MAC_DUAL}, 1'b0);
        chk("model_dual", {24'd0, m.c}, 64'h61D78);
        m = model(32'hFFFFFFFF, 8'hFF, {1'b0, MAC_QUAD}, 1'b0);
        chk("model_quad", {24'd0, m.c}, 64'hFEFFFFFF01);
        m = model(32'h12345678, 8'h9A, 3'b011, 1'b0);
        chk("model_illegal", {23'd0, m.err, m.c}, {23'd0, 1'b1, 40'd0});

        #1;
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_c",         {24'd0, bus.C},         64'd0);
        chk("rst_out_cfg",   {61'd0, bus.out_cfg},   64'd0);
        chk("rst_cfg_err",   {63'd0, bus.cfg_err},   64'd0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #2;

        // 1: SINGLE, upper lanes ignored, two-cycle latency
        send(32'h123456FF, 8'hFF, {1'b0, MAC_SINGLE}, 1'b0);
        chk("t1_not_yet", {63'd0, bus.out_valid}, 64'd0);
        @(posedge clk);
        #1;
        chk("t1_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("t1_c",     {24'd0, bus.C},         64'hFE01);
        chk("t1_err",   {63'd0, bus.cfg_err},   64'd0);
        wait_drain();

        // 2+3: DUAL then QUAD back to back, one result per cycle
        send(32'hAAAA1234, 8'h56, {1'b0, MAC_DUAL}, 1'b0);
        send(32'hFFFFFFFF, 8'hFF, {1'b0, MAC_QUAD}, 1'b0);
        chk("t2_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("t2_c",     {24'd0, bus.C},         64'h61D78);
        @(posedge clk);
        #1;
        chk("t3_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("t3_c",     {24'd0, bus.C},         64'hFEFFFFFF01);
        wait_drain();

        // 4: backpressure, two beats buffered, third waits
        bus.out_ready = 1'b0;
        send(32'h00000010, 8'h03, {1'b0, MAC_SINGLE}, 1'b0);
        send(32'h00000102, 8'h02, {1'b0, MAC_DUAL}, 1'b0);
        bus.A = 32'h01010101;
        bus.B = 8'h01;
        bus.cfg = {1'b0, MAC_QUAD};
        bus.in_valid = 1'b1;
        #1;
        chk("t4_full_ready", {63'd0, bus.in_ready}, 64'd0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk("t4_stall_ready", {63'd0, bus.in_ready}, 64'd0);
            chk("t4_stall_c",     {24'd0, bus.C},        64'h30);
        end
        bus.out_ready = 1'b1;
        send(32'h01010101, 8'h01, {1'b0, MAC_QUAD}, 1'b0);
        wait_drain();

        // 5: illegal cfg flows through as C=0 with cfg_err
        send(32'h12345678, 8'h9A, 3'b011, 1'b0);
        @(posedge clk);
        #1;
        chk("t5_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("t5_c",     {24'd0, bus.C},         64'd0);
        chk("t5_err",   {63'd0, bus.cfg_err},   64'd1);
        chk("t5_cfg",   {61'd0, bus.out_cfg},   64'd3);
        wait_drain();

        // 5b: reset mid-stream discards in-flight beats
        bus.out_ready = 1'b0;
        send(32'h0000_00AB, 8'h11, {1'b0, MAC_SINGLE}, 1'b0);
        send(32'h0000_CDEF, 8'h22, {1'b0, MAC_DUAL}, 1'b0);
        rst = 1'b0;
        #1;
        chk("t5_rst_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("t5_rst_c",     {24'd0, bus.C},         64'd0);
        chk("t5_rst_err",   {63'd0, bus.cfg_err},   64'd0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("t5_no_stale", {63'd0, bus.out_valid}, 64'd0);
        end
        @(posedge clk);
        #2;

`ifdef MAC_MUL_SIGNED_EN
        // 6: signed vs unsigned SINGLE
        send(32'h000000FF, 8'h02, {1'b0, MAC_SINGLE}, 1'b1);
        @(posedge clk);
        #1;
        chk("t6_signed", {24'd0, bus.C}, 64'hFFFFFFFFFE);
        wait_drain();
        send(32'h000000FF, 8'h02, {1'b0, MAC_SINGLE}, 1'b0);
        @(posedge clk);
        #1;
        chk("t6_unsigned", {24'd0, bus.C}, 64'h1FE);
        wait_drain();
`endif

        // Randomized traffic with backpressure and enable gaps
        for (int k = 0; k < 3000; k++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.A         = $urandom;
            bus.B         = 8'($urandom);
            bus.cfg       = 3'($urandom_range(0, 7));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            en            = ($urandom_range(0, 9) != 0);
`ifdef MAC_MUL_SIGNED_EN
            bus.in_signed = 1'($urandom);
`endif
            @(posedge clk);
            #2;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        en            = 1'b1;
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
